// File: rtl/serial_addsub_if.sv
// serial_addsub_if
//   Handshake and data bundle for the bit-serial adder/subtractor.
//   master : start, mode, a, b        (requester drives)
//            busy, done, result, carry_out, overflow (requester observes)
//   slave  : mirror image, used by serial_addsub.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, mode, a, b,
    input  busy, done, result, carry_out, overflow
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, result, carry_out, overflow
  );
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub
//   Bit-serial WIDTH-bit adder/subtractor. One full-adder cell and a carry
//   flop process the operands LSB first, one bit per clock.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears control and outputs
//   bus    : slave side of serial_addsub_if
//            start/mode/a/b in, busy/done/result/carry_out/overflow out
//   A request accepted in IDLE or DONE spends exactly WIDTH cycles in RUN,
//   then done pulses for one cycle with result and flags. Outputs only change
//   on the edge entering DONE, so partial sums are never visible.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_addsub_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             c_q, c_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;

  logic             b_bit;
  logic             s_bit;
  logic             c_next;
  logic             last_bit;
  logic [WIDTH-1:0] acc_shift;

  // Full-adder cell on the current LSBs; b is inverted for subtraction and
  // the carry flop was preloaded with mode, giving a + ~b + 1.
  always_comb begin
    b_bit     = b_q[0] ^ mode_q;
    s_bit     = a_q[0] ^ b_bit ^ c_q;
    c_next    = (a_q[0] & b_bit) | (c_q & (a_q[0] ^ b_bit));
    last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    acc_shift = (acc_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    c_d         = c_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          mode_d  = bus.mode;
          c_d     = bus.mode;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = c_next;
        acc_d = acc_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d     = DONE;
          result_d    = acc_shift;
          // Subtraction reports a borrow, the inverse of the raw carry.
          carry_out_d = mode_q ? ~c_next : c_next;
          // c_q is the carry into the MSB on the final bit.
          overflow_d  = c_q ^ c_next;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      c_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      c_q         <= c_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;

endmodule
